// File: rtl/cpu_pkg.sv
// Shared RV32I core types: opcodes, funct7 codes, decoded bundle, skid FSM states.
// Imported by the decode stage and the ALU.
package cpu_pkg;

  localparam int XLEN_P = 32;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MEXT = 7'b0000001;

  typedef struct packed {
    logic [6:0]        opcode;
    logic [4:0]        rd;
    logic [2:0]        funct3;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [6:0]        funct7;
    logic [XLEN_P-1:0] imm;
    logic [XLEN_P-1:0] pc;
    logic              illegal;
  } dec_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_e;

endpackage

// File: rtl/imm_gen.sv
// RV32I immediate generator: picks I/S/B/U/J format from the opcode
// and sign-extends; R-type and unknown opcodes yield zero.
module imm_gen
  import cpu_pkg::*;
(
  input  logic [31:0]       instr_i,
  output logic [XLEN_P-1:0] imm_o
);

  logic [6:0] opc;
  logic is_i, is_s, is_b, is_u, is_j;

  assign opc  = instr_i[6:0];
  assign is_i = (opc == OPC_LOAD) || (opc == OPC_OP_IMM)
             || (opc == OPC_JALR);
  assign is_s = (opc == OPC_STORE);
  assign is_b = (opc == OPC_BRANCH);
  assign is_u = (opc == OPC_LUI) || (opc == OPC_AUIPC);
  assign is_j = (opc == OPC_JAL);

  always_comb begin
    imm_o = '0;
    unique case (1'b1)
      is_i: imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
      is_s: imm_o = {{20{instr_i[31]}}, instr_i[31:25],
                     instr_i[11:7]};
      is_b: imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                     instr_i[30:25], instr_i[11:8], 1'b0};
      is_u: imm_o = {instr_i[31:12], 12'b0};
      is_j: imm_o = {{11{instr_i[31]}}, instr_i[31],
                     instr_i[19:12], instr_i[20],
                     instr_i[30:21], 1'b0};
      default: imm_o = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage with two-entry skid buffer in front of execute.
// Define DECODE_MEXT_EN to accept RV32M (funct7=0000001) R-type encodings.
module decode_stage
  import cpu_pkg::*;
#(
  parameter int              XLEN         = XLEN_P,
  parameter logic [XLEN-1:0] RESET_PC_TAG = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [6:0]      out_opcode,
  output logic [4:0]      out_rd,
  output logic [2:0]      out_funct3,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [6:0]      out_funct7,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_pc,
  output logic            out_illegal
);

  state_e state_q, state_d;
  dec_t   head_q, head_d;
  dec_t   skid_q, skid_d;
  dec_t   dec_in, empty_dec;
  logic   ready_q, valid_q;
  logic   acc, drain;
  logic [XLEN_P-1:0] imm_in;
  logic   ill;

  imm_gen u_imm_gen (
    .instr_i (in_instr),
    .imm_o   (imm_in)
  );

  always_comb begin
    ill = (in_instr[1:0] != 2'b11);
    unique case (in_instr[6:0])
      OPC_OP: begin
        unique case (in_instr[31:25])
          F7_BASE: ill = ill;
          F7_ALT:  ill = ill | ~((in_instr[14:12] == 3'b000)
                              || (in_instr[14:12] == 3'b101));
`ifdef DECODE_MEXT_EN
          F7_MEXT: ill = ill;
`else
          F7_MEXT: ill = 1'b1;
`endif
          default: ill = 1'b1;
        endcase
      end
      OPC_OP_IMM: begin
        if (in_instr[14:12] == 3'b001)
          ill = ill | (in_instr[31:25] != F7_BASE);
        else if (in_instr[14:12] == 3'b101)
          ill = ill | ~((in_instr[31:25] == F7_BASE)
                     || (in_instr[31:25] == F7_ALT));
      end
      OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR,
      OPC_LUI, OPC_AUIPC, OPC_FENCE, OPC_SYSTEM: ill = ill;
      default: ill = 1'b1;
    endcase
  end

  always_comb begin
    dec_in.opcode  = in_instr[6:0];
    dec_in.rd      = in_instr[11:7];
    dec_in.funct3  = in_instr[14:12];
    dec_in.rs1     = in_instr[19:15];
    dec_in.rs2     = in_instr[24:20];
    dec_in.funct7  = in_instr[31:25];
    dec_in.imm     = imm_in;
    dec_in.pc      = in_pc;
    dec_in.illegal = ill;
  end

  always_comb begin
    empty_dec    = '0;
    empty_dec.pc = RESET_PC_TAG;
  end

  assign acc   = in_valid & ready_q;
  assign drain = valid_q & out_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = S_EMPTY;
      head_d  = empty_dec;
    end else begin
      unique case (state_q)
        S_EMPTY: if (acc) begin
          state_d = S_ONE;
          head_d  = dec_in;
        end
        S_ONE: begin
          if (acc && !drain) begin
            state_d = S_TWO;
            skid_d  = dec_in;
          end else if (acc && drain) begin
            head_d  = dec_in;
          end else if (drain) begin
            state_d = S_EMPTY;
            head_d  = empty_dec;
          end
        end
        S_TWO: if (drain) begin
          state_d = S_ONE;
          head_d  = skid_q;
        end
        default: begin
          state_d = S_EMPTY;
          head_d  = empty_dec;
        end
      endcase
    end
  end

  // ready/valid are flopped from next state so in_ready never sees out_ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_EMPTY;
      head_q     <= '0;
      head_q.pc  <= RESET_PC_TAG;
      skid_q     <= '0;
      ready_q    <= 1'b1;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      skid_q     <= skid_d;
      ready_q    <= (state_d != S_TWO);
      valid_q    <= (state_d != S_EMPTY);
    end
  end

  assign in_ready    = ready_q;
  assign out_valid   = valid_q;
  assign out_opcode  = head_q.opcode;
  assign out_rd      = head_q.rd;
  assign out_funct3  = head_q.funct3;
  assign out_rs1     = head_q.rs1;
  assign out_rs2     = head_q.rs2;
  assign out_funct7  = head_q.funct7;
  assign out_imm     = head_q.imm;
  assign out_pc      = head_q.pc;
  assign out_illegal = head_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: scoreboard of expected decodes,
// directed handshake/flush/reset cases, then a random phase.
module tb_decode_stage;
  import cpu_pkg::*;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RST_TAG = 32'h0000_1000;
`ifdef DECODE_MEXT_EN
  localparam bit MEXT = 1'b1;
`else
  localparam bit MEXT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr;
  logic [XLEN-1:0] in_pc, out_imm, out_pc;
  logic [6:0] out_opcode, out_funct7;
  logic [4:0] out_rd, out_rs1, out_rs2;
  logic [2:0] out_funct3;
  logic out_illegal;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(XLEN), .RESET_PC_TAG(RST_TAG)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_rd(out_rd),
    .out_funct3(out_funct3), .out_rs1(out_rs1),
    .out_rs2(out_rs2), .out_funct7(out_funct7),
    .out_imm(out_imm), .out_pc(out_pc),
    .out_illegal(out_illegal)
  );

  int n_vec = 0;
  int n_err = 0;
  dec_t sb[$];
  bit   hold_pend = 1'b0;
  dec_t hold_snap;
  dec_t obs;

  assign obs = '{opcode: out_opcode, rd: out_rd,
                 funct3: out_funct3, rs1: out_rs1,
                 rs2: out_rs2, funct7: out_funct7,
                 imm: out_imm, pc: out_pc,
                 illegal: out_illegal};

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic dec_t model(input logic [31:0] w,
                                 input logic [31:0] pc);
    dec_t d;
    logic [6:0] op, f7;
    logic [2:0] f3;
    bit ill;
    op = w[6:0]; f7 = w[31:25]; f3 = w[14:12];
    d.opcode = op; d.rd = w[11:7]; d.funct3 = f3;
    d.rs1 = w[19:15]; d.rs2 = w[24:20]; d.funct7 = f7;
    d.pc = pc;
    case (op)
      7'h03, 7'h13, 7'h67:
        d.imm = 32'($signed(w[31:20]));
      7'h23:
        d.imm = 32'($signed({w[31:25], w[11:7]}));
      7'h63:
        d.imm = 32'($signed({w[31], w[7], w[30:25],
                             w[11:8], 1'b0}));
      7'h37, 7'h17:
        d.imm = {w[31:12], 12'h000};
      7'h6F:
        d.imm = 32'($signed({w[31], w[19:12], w[20],
                             w[30:21], 1'b0}));
      default: d.imm = 32'h0;
    endcase
    ill = (w[1:0] != 2'b11);
    case (op)
      7'h33: begin
        if (f7 == 7'h20) ill |= !(f3 == 3'd0 || f3 == 3'd5);
        else if (f7 == 7'h01) ill |= !MEXT;
        else if (f7 != 7'h00) ill = 1'b1;
      end
      7'h13: begin
        if (f3 == 3'd1) ill |= (f7 != 7'h00);
        if (f3 == 3'd5) ill |= !(f7 == 7'h00 || f7 == 7'h20);
      end
      7'h03, 7'h23, 7'h63, 7'h6F, 7'h67,
      7'h37, 7'h17, 7'h0F, 7'h73: ;
      default: ill = 1'b1;
    endcase
    d.illegal = ill;
    return d;
  endfunction

  // One cycle: at the falling edge check state, drive inputs, update
  // the scoreboard for the transfers that the next rising edge performs.
  task automatic step(input bit iv, input logic [31:0] w,
                      input logic [31:0] pc, input bit ordy,
                      input bit fl, output bit took);
    dec_t e;
    @(negedge clk);
    chk("out_valid", out_valid, sb.size() != 0);
    chk("in_ready", in_ready, sb.size() < 2);
    if (!out_valid) chk("empty_pc", out_pc, RST_TAG);
    if (hold_pend && out_valid) chk("hold", obs, hold_snap);
    in_valid = iv; in_instr = w; in_pc = pc;
    out_ready = ordy; flush = fl;
    took = iv && in_ready && !fl;
    if (out_valid && ordy && sb.size() != 0) begin
      e = sb.pop_front();
      chk("opcode", out_opcode, e.opcode);
      chk("rd", out_rd, e.rd);
      chk("funct3", out_funct3, e.funct3);
      chk("rs1", out_rs1, e.rs1);
      chk("rs2", out_rs2, e.rs2);
      chk("funct7", out_funct7, e.funct7);
      chk("imm", out_imm, e.imm);
      chk("pc", out_pc, e.pc);
      chk("illegal", out_illegal, e.illegal);
    end
    hold_pend = out_valid && !ordy && !fl;
    hold_snap = obs;
    if (fl) sb.delete();
    else if (took) sb.push_back(model(w, pc));
  endtask

  task automatic drain_all();
    bit t;
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 20) begin
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, t);
      n++;
    end
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, t);
    chk("drain_timeout", n < 20, 1'b1);
  endtask

  logic [31:0] pool [12] = '{
    32'h00500093, 32'hFFF00093, 32'hFE000EE3, 32'h402081B3,
    32'h022081B3, 32'h00000013, 32'h12345037, 32'hFE112E23,
    32'h0010106F, 32'h40105093, 32'h0000000F, 32'h00000073
  };

  initial begin
    bit t;
    int n;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
    in_instr = '0; in_pc = '0; out_ready = 1'b0;
    #12;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_ready", in_ready, 1'b1);
    chk("rst_pc", out_pc, RST_TAG);
    chk("rst_imm", out_imm, 32'h0);
    @(negedge clk); rst_n = 1'b1;

    // addi x1,x0,5
    step(1'b1, 32'h00500093, 32'h100, 1'b1, 1'b0, t);
    @(posedge clk); #1;
    chk("addi_imm", out_imm, 32'h5);
    chk("addi_rd", out_rd, 5'd1);
    chk("addi_op", out_opcode, 7'h13);
    drain_all();

    // back-to-back addi -1 then beq -4
    step(1'b1, 32'hFFF00093, 32'h200, 1'b1, 1'b0, t);
    step(1'b1, 32'hFE000EE3, 32'h204, 1'b1, 1'b0, t);
    chk("b2b_imm_a", out_imm, 32'hFFFFFFFF);
    chk("b2b_ready", in_ready, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, t);
    chk("b2b_imm_b", out_imm, 32'hFFFFFFFC);
    drain_all();

    // sub under backpressure, third instruction must wait
    step(1'b1, 32'h402081B3, 32'h300, 1'b0, 1'b0, t);
    step(1'b1, 32'h00500093, 32'h304, 1'b0, 1'b0, t);
    step(1'b1, 32'h022081B3, 32'h308, 1'b0, 1'b0, t);
    chk("two_ready", in_ready, 1'b0);
    chk("sub_funct7", out_funct7, 7'h20);
    chk("sub_rs2", out_rs2, 5'd2);
    chk("third_held", t, 1'b0);
    n = 0;
    while (!t && n < 10) begin
      step(1'b1, 32'h022081B3, 32'h308, 1'b1, 1'b0, t);
      n++;
    end
    chk("third_accept", t, 1'b1);
    drain_all();

    // mul: legality depends on the M-extension build
    step(1'b1, 32'h022081B3, 32'h400, 1'b1, 1'b0, t);
    @(posedge clk); #1;
    chk("mul_illegal", out_illegal, !MEXT);
    chk("mul_funct7", out_funct7, 7'h01);
    drain_all();

    // flush while full, with a same-cycle input
    step(1'b1, 32'h00100093, 32'h500, 1'b0, 1'b0, t);
    step(1'b1, 32'h00200093, 32'h504, 1'b0, 1'b0, t);
    step(1'b1, 32'h00300093, 32'h508, 1'b0, 1'b1, t);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, t);
    chk("flush_valid", out_valid, 1'b0);
    chk("flush_ready", in_ready, 1'b1);
    drain_all();

    // async reset mid-cycle while holding one entry
    step(1'b1, 32'h00700093, 32'h600, 1'b0, 1'b0, t);
    @(posedge clk); #1;
    chk("pre_rst_valid", out_valid, 1'b1);
    #2; in_valid = 1'b0; rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 1'b0);
    chk("arst_ready", in_ready, 1'b1);
    chk("arst_rd", out_rd, 5'd0);
    chk("arst_imm", out_imm, 32'h0);
    chk("arst_pc", out_pc, RST_TAG);
    sb.delete(); hold_pend = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    step(1'b1, 32'h00000013, 32'h700, 1'b1, 1'b0, t);
    chk("nop_accept", t, 1'b1);
    drain_all();

    // random traffic with occasional flush
    for (int i = 0; i < 300; i++) begin
      logic [31:0] w;
      w = ($urandom_range(0, 3) == 0) ? $urandom
                                      : pool[$urandom_range(0, 11)];
      step($urandom_range(0, 3) != 0, w, $urandom,
           $urandom_range(0, 2) != 0,
           $urandom_range(0, 24) == 0, t);
    end
    drain_all();

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
RV32I instruction decode pipeline stage. It sits directly upstream of the ALU. It accepts a fetched instruction word and PC over a valid/ready handshake, and splits the word into rd, funct3, rs1, rs2, funct7 and a sign-extended imm. It also flags illegal encodings, then presents the result registered to the ALU/execute stage. A two-entry skid buffer sustains full throughput under backpressure.

Parameters:
XLEN, 32, data/PC/immediate width
RESET_PC_TAG, 32'h0000_0000, value driven on out_pc while empty/after reset

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  discard all held instructions (branch redirect)
in_valid  input  1  instruction present from fetch
in_ready  output  1  stage can accept this cycle
in_instr  input  32  raw instruction word
in_pc  input  XLEN  PC of in_instr
out_valid  output  1  decoded instruction present
out_ready  input  1  ALU/execute accepts this cycle
out_opcode  output  7  instr[6:0]
out_rd  output  5  instr[11:7]
out_funct3  output  3  instr[14:12]
out_rs1  output  5  instr[19:15]
out_rs2  output  5  instr[24:20]
out_funct7  output  7  instr[31:25]
out_imm  output  XLEN  sign-extended immediate per format
out_pc  output  XLEN  PC of decoded instruction
out_illegal  output  1  illegal/unsupported encoding

Behaviour:
- Reset: asynchronous, active-low. While reset is asserted: state EMPTY, out_valid=0, in_ready=1, all out_* fields 0, out_pc=RESET_PC_TAG. Reset mid-transfer drops all held instructions.
- Transfers: input transfer when in_valid&&in_ready; output transfer when out_valid&&out_ready. Decoded outputs come from the head register only. Latency is 1 cycle: an instruction accepted at edge N appears on out_* after edge N.
- FSM states:
  - EMPTY: in_ready=1, out_valid=0. Accept moves to ONE.
  - ONE: in_ready=1, out_valid=1. Accept without drain moves to TWO (new entry goes to skid). Drain without accept moves to EMPTY. Drain plus accept stays ONE with new data in head.
  - TWO: in_ready=0, out_valid=1. Drain moves skid to head and goes to ONE.
- in_ready is a registered value, with no combinational path from out_ready.
- Outputs hold stable while out_valid=1 and out_ready=0.
- flush has priority over everything: next state EMPTY, and any same-cycle input is ignored. The same-cycle output transfer still counts as taken by the consumer.
- Decode is combinational on the incoming word and stored already-decoded, so outputs are plain register outputs.
- Immediate formats, keyed on opcode:
  - I (0000011, 0010011, 1100111): sext(instr[31:20]).
  - S (0100011): sext({[31:25],[11:7]}).
  - B (1100011): sext({[31],[7],[30:25],[11:8],0}).
  - U (0110111, 0010111): {[31:12],12'b0}.
  - J (1101111): sext({[31],[19:12],[20],[30:21],0}).
  - R (0110011) and all others: 0.
- out_illegal=1 when any of the following holds:
  - instr[1:0]!=2'b11.
  - opcode not in the set above plus 0001111/1110011.
  - R-type funct7 not 0000000/0100000.
  - R-type funct7=0100000 with funct3 not 000/101.
  - OP-IMM funct3=001 with funct7!=0000000.
  - OP-IMM funct3=101 with funct7 not 0000000/0100000.
- Illegal instructions still flow downstream with all fields decoded.

Optional Feature:
DECODE_MEXT_EN:
- Defined: R-type with funct7=0000001 (any funct3) is legal (RV32M).
- Undefined: such encodings set out_illegal=1.
- Field extraction is identical in both builds.

Decomposition:
- Shared package cpu_pkg: opcode localparams (OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC, OPC_FENCE, OPC_SYSTEM); funct7 constants F7_BASE, F7_ALT, F7_MEXT; a decoded-instruction struct typedef reused by the ALU; the FSM state enum.
- One sub-module: imm_gen (combinational instr -> imm format select and sign extension), instantiated once on the input path.

Test Plan:
- addi 0x00500093 with out_ready=1 → next cycle out_valid=1, rd=1, rs1=0, funct3=0, opcode=0x13, imm=0x00000005, illegal=0.
- 0xFFF00093 then beq 0xFE000EE3 back-to-back → imm 0xFFFFFFFF then 0xFFFFFFFC; one output per cycle, in_ready stays 1.
- sub 0x402081B3 with out_ready=0 for 3 cycles while in_valid held high → state TWO, in_ready=0 after the 2nd accept; outputs stable at rd=3, rs1=1, rs2=2, funct7=0x20; the 3rd instruction is not lost and emerges in order after out_ready=1.
- mul 0x022081B3 → out_illegal=1 without DECODE_MEXT_EN, 0 with it; funct7=0x01 in both builds.
- In state TWO assert flush together with in_valid → next cycle out_valid=0, in_ready=1; the flushed instructions and the same-cycle input never appear on the output.
- Drop rst_n asynchronously mid-cycle while in ONE → out_valid falls immediately, fields read 0, out_pc=RESET_PC_TAG; 0x00000013 (NOP) accepted normally after release.
